// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// FSM encoding, datapath widths and the default bus-wait limit.
package mem_access_ctrl_pkg;

    localparam int WORD_W          = 32;
    localparam int REG_W           = 5;
    localparam int CNT_W           = 8;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the write-back controls and holds
// the data fields; otherwise a load captures the full set of inputs.
import mem_access_ctrl_pkg::*;

module mem_wb_reg (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              bubble,
    input  logic              regwrite_in,
    input  logic              memtoreg_in,
    input  logic [WORD_W-1:0] readdata_in,
    input  logic [WORD_W-1:0] alu_result_in,
    input  logic [REG_W-1:0]  mux8_in,
    output logic              regwrite,
    output logic              memtoreg,
    output logic [WORD_W-1:0] readdata,
    output logic [WORD_W-1:0] alu_result,
    output logic [REG_W-1:0]  mux8
);

    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic [WORD_W-1:0] readdata_q, readdata_d;
    logic [WORD_W-1:0] alu_result_q, alu_result_d;
    logic [REG_W-1:0]  mux8_q, mux8_d;

    always_comb begin
        regwrite_d   = regwrite_q;
        memtoreg_d   = memtoreg_q;
        readdata_d   = readdata_q;
        alu_result_d = alu_result_q;
        mux8_d       = mux8_q;
        if (bubble) begin
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
        end else if (load) begin
            regwrite_d   = regwrite_in;
            memtoreg_d   = memtoreg_in;
            readdata_d   = readdata_in;
            alu_result_d = alu_result_in;
            mux8_d       = mux8_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            readdata_q   <= '0;
            alu_result_q <= '0;
            mux8_q       <= '0;
        end else begin
            regwrite_q   <= regwrite_d;
            memtoreg_q   <= memtoreg_d;
            readdata_q   <= readdata_d;
            alu_result_q <= alu_result_d;
            mux8_q       <= mux8_d;
        end
    end

    assign regwrite   = regwrite_q;
    assign memtoreg   = memtoreg_q;
    assign readdata   = readdata_q;
    assign alu_result = alu_result_q;
    assign mux8       = mux8_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues bus requests for aligned
// loads/stores, stalls the pipeline until ack or timeout, feeds MEM/WB.
import mem_access_ctrl_pkg::*;

module mem_access_ctrl #(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              MEM_MemRead,
    input  logic              MEM_MemWrite,
    input  logic              MEM_MemtoReg,
    input  logic              MEM_RegWrite,
    input  logic [WORD_W-1:0] MEM_ALU_result,
    input  logic [WORD_W-1:0] MEM_MUX6_out,
    input  logic [REG_W-1:0]  MEM_MUX8_out,
    output logic              bus_req,
    output logic              bus_we,
    output logic [WORD_W-1:0] bus_addr,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [WORD_W-1:0] bus_rdata,
    output logic              Stall,
    output logic              WB_RegWrite,
    output logic              WB_MemtoReg,
    output logic [WORD_W-1:0] WB_ReadData,
    output logic [WORD_W-1:0] WB_ALU_result,
    output logic [REG_W-1:0]  WB_MUX8_out,
    output logic              Misalign,
    output logic              BusErr
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [WORD_W-1:0] bus_addr_q, bus_addr_d;
    logic [WORD_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              lat_regwrite_q, lat_regwrite_d;
    logic              lat_memtoreg_q, lat_memtoreg_d;
    logic [REG_W-1:0]  lat_mux8_q, lat_mux8_d;
    logic              misalign_q, misalign_d;
    logic              buserr_q, buserr_d;

    logic              access, aligned, stall_c;
    logic              wb_regwrite, wb_memtoreg;
    logic [WORD_W-1:0] wb_readdata, wb_alu_result;
    logic [REG_W-1:0]  wb_mux8;

    assign access  = MEM_MemRead | MEM_MemWrite;
    assign aligned = (MEM_ALU_result[1:0] == 2'b00);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bus_req_d      = bus_req_q;
        bus_we_d       = bus_we_q;
        bus_addr_d     = bus_addr_q;
        bus_wdata_d    = bus_wdata_q;
        lat_regwrite_d = lat_regwrite_q;
        lat_memtoreg_d = lat_memtoreg_q;
        lat_mux8_d     = lat_mux8_q;
        misalign_d     = 1'b0;
        buserr_d       = 1'b0;
        stall_c        = 1'b0;
        wb_regwrite    = MEM_RegWrite;
        wb_memtoreg    = MEM_MemtoReg;
        wb_readdata    = '0;
        wb_alu_result  = MEM_ALU_result;
        wb_mux8        = MEM_MUX8_out;

        unique case (state_q)
            IDLE: begin
                bus_req_d = 1'b0;
                if (access && aligned) begin
                    // Read+write together is resolved as a write.
                    state_d        = WAIT;
                    cnt_d          = '0;
                    bus_req_d      = 1'b1;
                    bus_we_d       = MEM_MemWrite;
                    bus_addr_d     = MEM_ALU_result;
                    bus_wdata_d    = MEM_MUX6_out;
                    lat_regwrite_d = MEM_RegWrite;
                    lat_memtoreg_d = MEM_MemtoReg;
                    lat_mux8_d     = MEM_MUX8_out;
                    stall_c        = 1'b1;
                end else if (access) begin
                    misalign_d  = 1'b1;
                    wb_regwrite = 1'b0;
                end
            end
            WAIT: begin
                wb_regwrite   = lat_regwrite_q;
                wb_memtoreg   = lat_memtoreg_q;
                wb_readdata   = bus_we_q ? '0 : bus_rdata;
                wb_alu_result = bus_addr_q;
                wb_mux8       = lat_mux8_q;
                // An ack on the final allowed cycle still wins over the abort.
                if (bus_ack) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    bus_req_d   = 1'b0;
                    buserr_d    = 1'b1;
                    wb_regwrite = 1'b0;
                    wb_readdata = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    stall_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            lat_regwrite_q <= 1'b0;
            lat_memtoreg_q <= 1'b0;
            lat_mux8_q     <= '0;
            misalign_q     <= 1'b0;
            buserr_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus_req_q      <= bus_req_d;
            bus_we_q       <= bus_we_d;
            bus_addr_q     <= bus_addr_d;
            bus_wdata_q    <= bus_wdata_d;
            lat_regwrite_q <= lat_regwrite_d;
            lat_memtoreg_q <= lat_memtoreg_d;
            lat_mux8_q     <= lat_mux8_d;
            misalign_q     <= misalign_d;
            buserr_q       <= buserr_d;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk           (Clock),
        .rst_n         (Reset_n),
        .load          (~stall_c),
        .bubble        (stall_c),
        .regwrite_in   (wb_regwrite),
        .memtoreg_in   (wb_memtoreg),
        .readdata_in   (wb_readdata),
        .alu_result_in (wb_alu_result),
        .mux8_in       (wb_mux8),
        .regwrite      (WB_RegWrite),
        .memtoreg      (WB_MemtoReg),
        .readdata      (WB_ReadData),
        .alu_result    (WB_ALU_result),
        .mux8          (WB_MUX8_out)
    );

    assign Stall     = stall_c & Reset_n;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign Misalign  = misalign_q;
    assign BusErr    = buserr_q;

endmodule
